// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit
//
// Read-side stage between decode and ALU/LSU. It accepts a decoded
// instruction and reads rs1/rs2 through the register-file read ports. An
// 8-entry scoreboard of outstanding writes makes the stage stall on RAW and
// WAW hazards. Operands go to execute through a valid/ready pipeline
// register. The writeback bus (wb_iswb, wb_rd, wb_result) feeds back into the
// stage to clear scoreboard bits.
//
// Build option:
//   FWD_BYPASS_EN  When defined, a writeback in the same cycle is forwarded
//                  to the operands, and a register being written this cycle
//                  is not treated as busy. When undefined, operands always
//                  come from rf_rdata*. A dependent instruction is then
//                  accepted one cycle after its producer's writeback.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid/in_ready        decode-side handshake
//   in_rs1/in_rs2/in_rd      source and destination register indices
//   in_iswb/in_isld          writes-back flag; load flag (passed through)
//   rf_raddr1/rf_raddr2      register-file read addresses (= in_rs1/in_rs2)
//   rf_rdata1/rf_rdata2      register-file read data (pre-write values)
//   wb_iswb/wb_rd/wb_result  writeback bus
//   out_valid/out_ready      execute-side handshake
//   out_op1/out_op2          captured operands
//   out_rd/out_iswb/out_isld destination and flags passed through
//   stall_cnt                saturating count of cycles with in_valid & ~in_ready

module operand_fetch_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_iswb,
  input  logic              in_isld,

  output logic [AW-1:0]     rf_raddr1,
  output logic [AW-1:0]     rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,

  input  logic              wb_iswb,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_result,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [AW-1:0]     out_rd,
  output logic              out_iswb,
  output logic              out_isld,

  output logic [15:0]       stall_cnt
);

  // One bit per architectural register: a write to it is still in flight.
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;

  logic              busy_rs1;
  logic              busy_rs2;
  logic              busy_rd;
  logic              hazard;
  logic              accept;
  logic              stalled;
  logic [DATA_W-1:0] op1_sel;
  logic [DATA_W-1:0] op2_sel;

  // Read addresses come straight from decode so the register file can
  // return data in the same cycle.
  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

`ifdef FWD_BYPASS_EN
  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic wb_hit_rd;

  assign wb_hit_rs1 = wb_iswb & (wb_rd == in_rs1);
  assign wb_hit_rs2 = wb_iswb & (wb_rd == in_rs2);
  assign wb_hit_rd  = wb_iswb & (wb_rd == in_rd);

  // A register that retires this cycle is not busy. Its value is taken
  // from the writeback bus because rf_rdata still holds the old contents.
  assign busy_rs1 = pending_q[in_rs1] & ~wb_hit_rs1;
  assign busy_rs2 = pending_q[in_rs2] & ~wb_hit_rs2;
  assign busy_rd  = pending_q[in_rd]  & ~wb_hit_rd;

  assign op1_sel = wb_hit_rs1 ? wb_result : rf_rdata1;
  assign op2_sel = wb_hit_rs2 ? wb_result : rf_rdata2;
`else
  // Without the bypass the writeback data path is not used. The reduction
  // keeps the port visibly consumed.
  logic unused_wb_result;
  assign unused_wb_result = ^wb_result;

  assign busy_rs1 = pending_q[in_rs1];
  assign busy_rs2 = pending_q[in_rs2];
  assign busy_rd  = pending_q[in_rd];

  assign op1_sel = rf_rdata1;
  assign op2_sel = rf_rdata2;
`endif

  // The rd term is the WAW stall. It keeps at most one outstanding write
  // per register, so a single pending bit is enough to track it.
  assign hazard   = in_valid & (busy_rs1 | busy_rs2 | (in_iswb & busy_rd));
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;
  assign stalled  = in_valid & ~in_ready;

  // The clear is applied first so that a set to the same index on the same
  // edge wins. The new producer must stay tracked.
  always_comb begin
    pending_d = pending_q;
    if (wb_iswb) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (accept && in_iswb) begin
      pending_d[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Output pipeline register. It loads only on accept, so the payload holds
  // stable while execute back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_iswb  <= 1'b0;
      out_isld  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= op1_sel;
      out_op2   <= op2_sel;
      out_rd    <= in_rd;
      out_iswb  <= in_iswb;
      out_isld  <= in_isld;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
module tb_operand_fetch_unit;

`ifdef FWD_BYPASS_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rs1;
  logic [2:0]  in_rs2;
  logic [2:0]  in_rd;
  logic        in_iswb;
  logic        in_isld;
  logic [2:0]  rf_raddr1;
  logic [2:0]  rf_raddr2;
  logic [15:0] rf_rdata1;
  logic [15:0] rf_rdata2;
  logic        wb_iswb;
  logic [2:0]  wb_rd;
  logic [15:0] wb_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_op1;
  logic [15:0] out_op2;
  logic [2:0]  out_rd;
  logic        out_iswb;
  logic        out_isld;
  logic [15:0] stall_cnt;

  int checks;
  int failures;

  operand_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_iswb   (in_iswb),
    .in_isld   (in_isld),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_iswb   (wb_iswb),
    .wb_rd     (wb_rd),
    .wb_result (wb_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op1   (out_op1),
    .out_op2   (out_op2),
    .out_rd    (out_rd),
    .out_iswb  (out_iswb),
    .out_isld  (out_isld),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    in_iswb   = 1'b0;
    in_isld   = 1'b0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    wb_iswb   = 1'b0;
    wb_rd     = '0;
    wb_result = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_op1 !== 16'h0 || out_op2 !== 16'h0 || out_rd !== 3'd0 ||
        out_iswb !== 1'b0 || out_isld !== 1'b0 || stall_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b op1=%h op2=%h rd=%0d iswb=%b isld=%b stall=%0d, want all 0",
               out_valid, out_op1, out_op2, out_rd, out_iswb, out_isld, stall_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_rs1 = 3'd1; in_rs2 = 3'd2; in_rd = 3'd6; in_iswb = 1'b0; in_isld = 1'b1;
    rf_rdata1 = 16'hABCD; rf_rdata2 = 16'h1234; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || rf_raddr1 !== 3'd1 || rf_raddr2 !== 3'd2) begin
      failures++;
      $display("FAIL basic_issue: in_ready=%b raddr1=%0d raddr2=%0d, want 1/1/2",
               in_ready, rf_raddr1, rf_raddr2);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 16'hABCD || out_op2 !== 16'h1234 || out_rd !== 3'd6 ||
        out_iswb !== 1'b0 || out_isld !== 1'b1) begin
      failures++;
      $display("FAIL basic_out: valid=%b op1=%h op2=%h rd=%0d iswb=%b isld=%b, want 1 abcd 1234 6 0 1",
               out_valid, out_op1, out_op2, out_rd, out_iswb, out_isld);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_raw();
    idle_inputs();
    in_valid = 1'b1; in_iswb = 1'b1; in_rd = 3'd2;
    tick();
    in_iswb = 1'b0; in_rd = 3'd1; in_rs1 = 3'd2; in_rs2 = 3'd0; rf_rdata1 = 16'hDEAD;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL raw_stall: in_ready=%b want 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (stall_cnt !== 16'd2) begin
      failures++;
      $display("FAIL raw_stall_cnt: got %0d want 2", stall_cnt);
    end
    wb_iswb = 1'b1; wb_rd = 3'd2; wb_result = 16'h1234;
    #1;
`ifdef FWD_BYPASS_EN
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_fwd_accept: in_ready=%b want 1", in_ready);
    end
    tick();
    wb_iswb = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 16'h1234 || stall_cnt !== 16'd2) begin
      failures++;
      $display("FAIL raw_fwd_out: valid=%b op1=%h stall=%0d, want 1 1234 2",
               out_valid, out_op1, stall_cnt);
    end
`else
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL raw_nofwd_wbcycle: in_ready=%b want 0", in_ready);
    end
    tick();
    wb_iswb = 1'b0; rf_rdata1 = 16'h1234;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_nofwd_accept: in_ready=%b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 16'h1234 || stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL raw_nofwd_out: valid=%b op1=%h stall=%0d, want 1 1234 3",
               out_valid, out_op1, stall_cnt);
    end
`endif
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_waw();
    idle_inputs();
    in_valid = 1'b1; in_iswb = 1'b1; in_rd = 3'd3; in_rs1 = 3'd0; in_rs2 = 3'd1;
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_stall: in_ready=%b want 0", in_ready);
    end
    tick();
    tick();
    wb_iswb = 1'b1; wb_rd = 3'd3; wb_result = 16'h0;
`ifdef FWD_BYPASS_EN
    #1;
`else
    tick();
    wb_iswb = 1'b0;
    #1;
`endif
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL waw_accept: in_ready=%b want 1", in_ready);
    end
    tick();
    wb_iswb = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 3'd3 || out_iswb !== 1'b1) begin
      failures++;
      $display("FAIL waw_out: valid=%b rd=%0d iswb=%b, want 1 3 1", out_valid, out_rd, out_iswb);
    end
    in_iswb = 1'b0; in_rs1 = 3'd3; in_rd = 3'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_repending: in_ready=%b want 0 (r3 pending again)", in_ready);
    end
    in_valid = 1'b0; wb_iswb = 1'b1; wb_rd = 3'd3;
    tick();
    wb_iswb = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    in_valid = 1'b1; in_rs1 = 3'd4; in_rs2 = 3'd5; in_rd = 3'd5;
    rf_rdata1 = 16'h1111; rf_rdata2 = 16'h2222;
    tick();
    out_ready = 1'b0; in_rd = 3'd6; rf_rdata1 = 16'h3333; rf_rdata2 = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_op1 !== 16'h1111 || out_op2 !== 16'h2222 || out_rd !== 3'd5) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b op1=%h op2=%h rd=%0d, want 1 1111 2222 5",
                 i, out_valid, out_op1, out_op2, out_rd);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 16'h3333 || out_op2 !== 16'h4444 || out_rd !== 3'd6) begin
      failures++;
      $display("FAIL bp_b2b: valid=%b op1=%h op2=%h rd=%0d, want 1 3333 4444 6",
               out_valid, out_op1, out_op2, out_rd);
    end
    tick();
  endtask

  task automatic test_same_edge();
    idle_inputs();
    in_valid = 1'b1; in_iswb = 1'b1; in_rd = 3'd4; in_rs1 = 3'd0; in_rs2 = 3'd1;
    wb_iswb = 1'b1; wb_rd = 3'd4;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL same_edge_accept: in_ready=%b want 1", in_ready);
    end
    tick();
    wb_iswb = 1'b0; in_iswb = 1'b0; in_rs1 = 3'd4; in_rd = 3'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_set_wins: in_ready=%b want 0 (r4 pending)", in_ready);
    end
    in_valid = 1'b0; wb_iswb = 1'b1; wb_rd = 3'd4;
    tick();
    wb_iswb = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid = 1'b1; in_iswb = 1'b1; in_rd = 3'd5; rf_rdata1 = 16'h7777;
    tick();
    out_ready = 1'b0; in_iswb = 1'b0; in_rd = 3'd1; in_rs1 = 3'd5; rf_rdata1 = 16'h5555;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || out_op1 !== 16'h0 || out_rd !== 3'd0 ||
        out_iswb !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b stall=%0d op1=%h rd=%0d iswb=%b, want all 0",
               out_valid, stall_cnt, out_op1, out_rd, out_iswb);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_op1 !== 16'h5555) begin
      failures++;
      $display("FAIL reset_mid_accept: valid=%b op1=%h, want 1 5555", out_valid, out_op1);
    end
    tick();
  endtask

  // Random traffic against a transaction-level model: a set of registers
  // with writes in flight, plus a single slot holding the last operand bundle.
  task automatic test_random();
    bit          pend [8];
    bit          mv;
    logic [15:0] m_op1;
    logic [15:0] m_op2;
    logic [2:0]  m_rd;
    bit          m_iswb;
    bit          m_isld;
    int          m_stall;
    bit          exp_rdy;
    bit          acc;
    bit          haz;
    int          cand [$];

    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 8; r++) pend[r] = 1'b0;
    mv = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_iswb = 1'b0; m_isld = 1'b0; m_stall = 0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_rs1    = 3'($urandom_range(0, 7));
      in_rs2    = 3'($urandom_range(0, 7));
      in_rd     = 3'($urandom_range(0, 7));
      in_iswb   = $urandom_range(0, 1) == 1;
      in_isld   = $urandom_range(0, 1) == 1;
      rf_rdata1 = 16'($urandom);
      rf_rdata2 = 16'($urandom);
      wb_result = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cand.delete();
      for (int r = 0; r < 8; r++) if (pend[r]) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 9) < 5) begin
        wb_iswb = 1'b1;
        wb_rd   = 3'(cand[$urandom_range(0, cand.size() - 1)]);
      end else begin
        wb_iswb = ($urandom_range(0, 9) < 1);
        wb_rd   = 3'($urandom_range(0, 7));
      end

      // A source is busy while its write is in flight, unless (with bypass)
      // that write retires right now.
      haz = in_valid &&
            ((pend[in_rs1] && !(Fwd && wb_iswb && wb_rd == in_rs1)) ||
             (pend[in_rs2] && !(Fwd && wb_iswb && wb_rd == in_rs2)) ||
             (in_iswb && pend[in_rd] && !(Fwd && wb_iswb && wb_rd == in_rd)));
      exp_rdy = (!mv || out_ready) && !haz;
      #1;
      checks++;
      if (in_ready !== exp_rdy || rf_raddr1 !== in_rs1 || rf_raddr2 !== in_rs2) begin
        failures++;
        $display("FAIL rand_ready[%0d]: in_ready=%b raddr=%0d/%0d want %b %0d/%0d",
                 cyc, in_ready, rf_raddr1, rf_raddr2, exp_rdy, in_rs1, in_rs2);
      end

      acc = in_valid && exp_rdy;
      if (wb_iswb) pend[wb_rd] = 1'b0;
      if (acc && in_iswb) pend[in_rd] = 1'b1;
      if (acc) begin
        mv     = 1'b1;
        m_op1  = (Fwd && wb_iswb && wb_rd == in_rs1) ? wb_result : rf_rdata1;
        m_op2  = (Fwd && wb_iswb && wb_rd == in_rs2) ? wb_result : rf_rdata2;
        m_rd   = in_rd;
        m_iswb = in_iswb;
        m_isld = in_isld;
      end else if (out_ready) begin
        mv = 1'b0;
      end
      if (in_valid && !exp_rdy && m_stall < 65535) m_stall++;

      tick();
      checks++;
      if (out_valid !== mv || stall_cnt !== 16'(m_stall)) begin
        failures++;
        $display("FAIL rand_valid[%0d]: out_valid=%b stall=%0d want %b %0d",
                 cyc, out_valid, stall_cnt, mv, m_stall);
      end
      if (mv) begin
        checks++;
        if (out_op1 !== m_op1 || out_op2 !== m_op2 || out_rd !== m_rd ||
            out_iswb !== m_iswb || out_isld !== m_isld) begin
          failures++;
          $display("FAIL rand_payload[%0d]: op1=%h op2=%h rd=%0d iswb=%b isld=%b want %h %h %0d %b %b",
                   cyc, out_op1, out_op2, out_rd, out_iswb, out_isld,
                   m_op1, m_op2, m_rd, m_iswb, m_isld);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_basic();
    test_raw();
    test_waw();
    test_backpressure();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Read-side counterpart of the writeback unit. Accepts decoded instructions, reads rs1/rs2 through the register-file read ports, and forwards same-cycle writeback data.
- Tracks outstanding writes in an 8-entry scoreboard and stalls on RAW/WAW hazards.
- Presents operands to execute through a valid/ready pipeline register.
- Sits between decode and ALU/LSU. Fed back by the writeback bus (iswb, rd, result).

Parameters:
DATA_W, 16, operand/result width
NREG, 8, architectural register count
AW, 3, register index width (log2 NREG)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage can accept this cycle
in_rs1  input  AW  source register 1
in_rs2  input  AW  source register 2
in_rd  input  AW  destination register
in_iswb  input  1  instruction will write back rd
in_isld  input  1  instruction is a load (passed through)
rf_raddr1  output  AW  register-file read address 1 (= in_rs1, combinational)
rf_raddr2  output  AW  register-file read address 2 (= in_rs2, combinational)
rf_rdata1  input  DATA_W  register-file read data 1 (combinational, pre-write value)
rf_rdata2  input  DATA_W  register-file read data 2
wb_iswb  input  1  writeback occurring this cycle
wb_rd  input  AW  writeback destination
wb_result  input  DATA_W  writeback value (ALU or load result)
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts this cycle
out_op1  output  DATA_W  operand 1
out_op2  output  DATA_W  operand 2
out_rd  output  AW  destination passed through
out_iswb  output  1  passed through
out_isld  output  1  passed through
stall_cnt  output  16  saturating count of cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset (async, rst=1): pending[NREG-1:0]=0, out_valid=0, out_op1/out_op2=0, out_rd=0, out_iswb=0, out_isld=0, stall_cnt=0. Reset mid-transfer discards the held instruction.
- Writeback clear: wb_iswb=1 clears pending[wb_rd] at the clock edge.
- Per-source hazard: src_busy(rs) = pending[rs] & ~(wb_iswb & wb_rd==rs).
- Stall conditions:
  - hazard = in_valid & (src_busy(rs1) | src_busy(rs2) | (in_iswb & src_busy(rd))).
  - The rd term is a WAW stall, so at most one outstanding write exists per register.
- in_ready = (~out_valid | out_ready) & ~hazard. Accept = in_valid & in_ready.
- Operand select on accept:
  - out_op1 = (wb_iswb & wb_rd==in_rs1) ? wb_result : rf_rdata1. Same rule for out_op2.
  - Capture rd/iswb/isld. Set out_valid=1.
  - Latency: one cycle from accept to out_valid.
- Scoreboard set: on accept with in_iswb=1, set pending[in_rd].
  - If the same edge also clears the same index, set wins.
- Output handshake:
  - If out_valid & out_ready & ~accept, then out_valid goes to 0.
  - While out_valid & ~out_ready, all out_* hold stable.
- Register 0 is an ordinary register with no hardwired zero.
- A writeback to a non-pending register only clears a 0 bit, with no side effects.
- stall_cnt increments when in_valid & ~in_ready and saturates at 16'hFFFF.

Optional Feature:
FWD_BYPASS_EN
- Defined:
  - Same-cycle wb_result forwarding to out_op1/out_op2.
  - src_busy excludes registers being written this cycle, as specified above.
- Undefined:
  - No forwarding. src_busy(rs) = pending[rs].
  - Operands always come from rf_rdata*.
  - A dependent instruction accepts one cycle after its producer's writeback.

Test Plan:
1. Reset, then issue rs1=1, rs2=2 with rf_rdata1=16'hABCD, rf_rdata2=16'h1234, out_ready=1 -> next cycle out_valid=1, out_op1=ABCD, out_op2=1234.
2. Issue rd=2 with iswb=1, then a consumer with rs1=2 -> in_ready=0 and stall_cnt counts up. Then wb_iswb=1, wb_rd=2, wb_result=16'h1234:
   - with FWD_BYPASS_EN: accepted that cycle, out_op1=1234.
   - without FWD_BYPASS_EN: accepted the next cycle.
3. Issue iswb=1, rd=3, then another iswb=1, rd=3 with no writeback -> second instruction stalls (WAW). After wb_rd=3, it is accepted and pending[3]=1 again.
4. out_ready=0 with out_valid=1 and a new in_valid -> in_ready=0; out_op1/out_op2/out_rd hold for 3 cycles. Raise out_ready -> back-to-back transfer with no bubble.
5. Same edge: accept iswb=1, rd=4 and wb_iswb=1, wb_rd=4 -> pending[4]=1 after the edge.
6. Assert rst mid-stall with pending[5]=1 and out_valid=1 -> immediate pending=0, out_valid=0, stall_cnt=0. A consumer of r5 is accepted the first cycle after reset.
